// File: rtl/pentary_pkg.sv
// Shared definitions for balanced-pentary arithmetic.
// Digit codes 000..100 map to -2..+2; 101..111 are illegal.
package pentary_pkg;

    localparam int PENT_W = 3;

    localparam logic [2:0] PENT_M2 = 3'b000;
    localparam logic [2:0] PENT_M1 = 3'b001;
    localparam logic [2:0] PENT_Z  = 3'b010;
    localparam logic [2:0] PENT_P1 = 3'b011;
    localparam logic [2:0] PENT_P2 = 3'b100;

    function automatic logic [2:0] pent_neg(input logic [2:0] code);
        return 3'b100 - code;
    endfunction

    function automatic logic pent_is_legal(input logic [2:0] code);
        return code <= PENT_P2;
    endfunction

    function automatic logic signed [3:0] pent_val(input logic [2:0] code);
        return $signed({1'b0, code}) - 4'sd2;
    endfunction

    function automatic logic [2:0] pent_enc(input logic signed [3:0] v);
        logic [3:0] u;
        u = v + 4'sd2;
        return u[2:0];
    endfunction

endpackage

// File: rtl/pentary_chunk_adder.sv
// Combinational ripple of balanced-pentary digit cells over one
// pipeline chunk, with carry in and carry out.
module pentary_chunk_adder
    import pentary_pkg::*;
#(
    parameter int STAGE_DIGITS = 4
) (
    input  logic [PENT_W*STAGE_DIGITS-1:0] a,
    input  logic [PENT_W*STAGE_DIGITS-1:0] b,
    input  logic [2:0]                     cin,
    output logic [PENT_W*STAGE_DIGITS-1:0] sum,
    output logic [2:0]                     cout
);

    logic [2:0]        c;
    logic signed [3:0] t;

    always_comb begin
        c   = cin;
        t   = '0;
        sum = '0;
        for (int i = 0; i < STAGE_DIGITS; i++) begin
            t = pent_val(a[i*PENT_W +: PENT_W])
              + pent_val(b[i*PENT_W +: PENT_W])
              + pent_val(c);
            if (t > 4'sd2) begin
                sum[i*PENT_W +: PENT_W] = pent_enc(t - 4'sd5);
                c = PENT_P1;
            end else if (t < -4'sd2) begin
                sum[i*PENT_W +: PENT_W] = pent_enc(t + 4'sd5);
                c = PENT_M1;
            end else begin
                sum[i*PENT_W +: PENT_W] = pent_enc(t);
                c = PENT_Z;
            end
        end
        cout = c;
    end

endmodule

// File: rtl/pentary_addsub_pipe.sv
// Pipelined balanced-pentary adder/subtractor, one chunk per stage,
// with a single global advance enable for valid/ready backpressure.
module pentary_addsub_pipe
    import pentary_pkg::*;
#(
    parameter int DIGITS       = 16,
    parameter int STAGE_DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PENT_W*DIGITS-1:0] in_a,
    input  logic [PENT_W*DIGITS-1:0] in_b,
    input  logic [2:0]               in_carry,
    input  logic                     in_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PENT_W*DIGITS-1:0] out_sum,
    output logic [2:0]               out_carry,
    output logic                     out_invalid
);

    localparam int STAGES = DIGITS / STAGE_DIGITS;
    localparam int W      = PENT_W * DIGITS;
    localparam int CW     = PENT_W * STAGE_DIGITS;

    localparam logic [W-1:0] ZERO_W = {DIGITS{PENT_Z}};

    logic         adv;
    logic         bad;
    logic [W-1:0] b_eff;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [2:0]   c0;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Illegal operations are squashed to 0+0+0 so they flush as zeros.
    always_comb begin
        bad   = !(in_carry == PENT_M1 ||
                  in_carry == PENT_Z  ||
                  in_carry == PENT_P1);
        b_eff = in_b;
        for (int i = 0; i < DIGITS; i++) begin
            if (!pent_is_legal(in_a[i*PENT_W +: PENT_W]) ||
                !pent_is_legal(in_b[i*PENT_W +: PENT_W]))
                bad = 1'b1;
            if (in_sub)
                b_eff[i*PENT_W +: PENT_W] = pent_neg(in_b[i*PENT_W +: PENT_W]);
        end
        a0 = bad ? ZERO_W : in_a;
        b0 = bad ? ZERO_W : b_eff;
        c0 = bad ? PENT_Z : in_carry;
    end

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int HI = W - k*CW;
        localparam int LO = (k+1)*CW;

        logic [HI-1:0] a_src;
        logic [HI-1:0] b_src;
        logic [2:0]    c_src;
        logic [2:0]    c_out;
        logic [2:0]    c_q;
        logic          v_src;
        logic          x_src;
        logic          v_q;
        logic          x_q;
        logic [CW-1:0] chunk;
        logic [LO-1:0] s_next;
        logic [LO-1:0] s_q;

        if (k == 0) begin : head
            assign a_src  = a0;
            assign b_src  = b0;
            assign c_src  = c0;
            assign v_src  = in_valid;
            assign x_src  = bad;
            assign s_next = chunk;
        end else begin : body
            assign a_src  = stg[k-1].fwd.a_q;
            assign b_src  = stg[k-1].fwd.b_q;
            assign c_src  = stg[k-1].c_q;
            assign v_src  = stg[k-1].v_q;
            assign x_src  = stg[k-1].x_q;
            assign s_next = {chunk, stg[k-1].s_q};
        end

        pentary_chunk_adder #(
            .STAGE_DIGITS(STAGE_DIGITS)
        ) u_chunk (
            .a    (a_src[CW-1:0]),
            .b    (b_src[CW-1:0]),
            .cin  (c_src),
            .sum  (chunk),
            .cout (c_out)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                x_q <= 1'b0;
                c_q <= PENT_Z;
                s_q <= {((k+1)*STAGE_DIGITS){PENT_Z}};
            end else if (adv) begin
                v_q <= v_src;
                x_q <= x_src;
                c_q <= c_out;
                s_q <= s_next;
            end
        end

        // Operand digits not yet resolved ride along to later stages.
        if (k < STAGES-1) begin : fwd
            logic [HI-CW-1:0] a_q;
            logic [HI-CW-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= {(HI/PENT_W-STAGE_DIGITS){PENT_Z}};
                    b_q <= {(HI/PENT_W-STAGE_DIGITS){PENT_Z}};
                end else if (adv) begin
                    a_q <= a_src[HI-1:CW];
                    b_q <= b_src[HI-1:CW];
                end
            end
        end
    end

    assign out_valid   = stg[STAGES-1].v_q;
    assign out_invalid = stg[STAGES-1].x_q;
    assign out_carry   = stg[STAGES-1].c_q;
    assign out_sum     = stg[STAGES-1].s_q;

endmodule

// File: tb/tb_pentary_addsub_pipe.sv
// Bench for pentary_addsub_pipe: directed table on a 16/4 instance,
// scoreboarded streams on 16/4 and randomized traffic on 8/2.
module tb_pentary_addsub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv16, ir16, sub16, ov16, or16, inv16;
    logic [47:0] a16, b16, s16;
    logic [2:0]  c16, co16;

    logic        iv8, ir8, sub8, ov8, or8, inv8;
    logic [23:0] a8, b8, s8;
    logic [2:0]  c8, co8;

    pentary_addsub_pipe #(.DIGITS(16), .STAGE_DIGITS(4)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(iv16), .in_ready(ir16),
        .in_a(a16), .in_b(b16), .in_carry(c16), .in_sub(sub16),
        .out_valid(ov16), .out_ready(or16),
        .out_sum(s16), .out_carry(co16), .out_invalid(inv16)
    );

    pentary_addsub_pipe #(.DIGITS(8), .STAGE_DIGITS(2)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8),
        .in_a(a8), .in_b(b8), .in_carry(c8), .in_sub(sub8),
        .out_valid(ov8), .out_ready(or8),
        .out_sum(s8), .out_carry(co8), .out_invalid(inv8)
    );

    typedef struct {
        logic [47:0] s;
        logic [2:0]  c;
        logic        inv;
    } exp_t;

    typedef struct {
        string       name;
        logic [47:0] a;
        logic [47:0] b;
        logic [2:0]  cin;
        logic        sub;
        logic [47:0] s;
        logic [2:0]  co;
        logic        inv;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic longint pval(input logic [47:0] v, input int n);
        longint r = 0;
        longint w = 1;
        for (int i = 0; i < n; i++) begin
            r += (longint'(v[3*i +: 3]) - 2) * w;
            w *= 5;
        end
        return r;
    endfunction

    // Reference: integer arithmetic, then balanced base-5 conversion.
    function automatic exp_t model(input logic [47:0] a, input logic [47:0] b,
                                   input logic [2:0] c, input logic sub,
                                   input int n);
        exp_t   e;
        longint t;
        longint r;
        e.s   = '0;
        e.c   = 3'b010;
        e.inv = (c < 3'd1) || (c > 3'd3);
        for (int i = 0; i < n; i++)
            if (a[3*i +: 3] > 3'd4 || b[3*i +: 3] > 3'd4) e.inv = 1'b1;
        if (e.inv) begin
            for (int i = 0; i < n; i++) e.s[3*i +: 3] = 3'b010;
            return e;
        end
        t = pval(a, n) + (sub ? -pval(b, n) : pval(b, n)) + longint'(c) - 2;
        for (int i = 0; i < n; i++) begin
            r = t % 5;
            if (r > 2)  r -= 5;
            if (r < -2) r += 5;
            e.s[3*i +: 3] = 3'(r + 2);
            t = (t - r) / 5;
        end
        e.c = 3'(t + 2);
        return e;
    endfunction

    function automatic logic [47:0] rnd_op(input int n);
        logic [47:0] v = '0;
        for (int i = 0; i < n; i++) v[3*i +: 3] = 3'($urandom_range(0, 4));
        return v;
    endfunction

    function automatic logic [47:0] rep16(input logic [2:0] c);
        return {16{c}};
    endfunction

    function automatic vec_t mk(input string nm, input logic [47:0] a,
                                input logic [47:0] b, input logic [2:0] cin,
                                input logic sub, input logic [47:0] s,
                                input logic [2:0] co, input logic inv);
        vec_t v;
        v.name = nm; v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.s = s; v.co = co; v.inv = inv;
        return v;
    endfunction

    exp_t q16[$];
    exp_t q8[$];
    exp_t e16, e8;
    int   got16 = 0;
    int   got8  = 0;
    bit   mon16 = 1'b0;
    bit   held16 = 1'b0, held8 = 1'b0;
    logic [47:0] hs16;
    logic [23:0] hs8;
    logic [2:0]  hc16, hc8;
    logic        hi16, hi8;

    // Handshakes are judged mid-cycle; they complete at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            q16.delete();
            q8.delete();
            held16 = 1'b0;
            held8  = 1'b0;
        end else begin
            check("in_ready16 rule", ir16, !ov16 || or16);
            check("in_ready8 rule", ir8, !ov8 || or8);
            if (mon16) begin
                if (held16) begin
                    check("stall16 valid", ov16, 1'b1);
                    check("stall16 sum", s16, hs16);
                    check("stall16 carry", co16, hc16);
                    check("stall16 invalid", inv16, hi16);
                end
                held16 = ov16 && !or16;
                hs16 = s16; hc16 = co16; hi16 = inv16;
                if (ov16 && or16) begin
                    if (q16.size() == 0) begin
                        check("spurious16", 1'b1, 1'b0);
                    end else begin
                        e16 = q16.pop_front();
                        check("stream16 sum", s16, e16.s);
                        check("stream16 carry", co16, e16.c);
                        check("stream16 invalid", inv16, e16.inv);
                        got16++;
                    end
                end
                if (iv16 && ir16)
                    q16.push_back(model(a16, b16, c16, sub16, 16));
            end
            if (held8) begin
                check("stall8 sum", s8, hs8);
                check("stall8 carry", co8, hc8);
                check("stall8 invalid", inv8, hi8);
            end
            held8 = ov8 && !or8;
            hs8 = s8; hc8 = co8; hi8 = inv8;
            if (ov8 && or8) begin
                if (q8.size() == 0) begin
                    check("spurious8", 1'b1, 1'b0);
                end else begin
                    e8 = q8.pop_front();
                    check("rand8 sum", s8, e8.s);
                    check("rand8 carry", co8, e8.c);
                    check("rand8 invalid", inv8, e8.inv);
                    got8++;
                end
            end
            if (iv8 && ir8)
                q8.push_back(model({24'b0, a8}, {24'b0, b8}, c8, sub8, 8));
        end
    end

    task automatic run_vec(input vec_t v);
        int lat;
        a16 = v.a; b16 = v.b; c16 = v.cin; sub16 = v.sub;
        iv16 = 1'b1; or16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        lat = 1;
        while (!ov16 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({v.name, " latency"}, lat, 4);
        check({v.name, " sum"}, s16, v.s);
        check({v.name, " carry"}, co16, v.co);
        check({v.name, " invalid"}, inv16, v.inv);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t        tbl[8];
    logic [47:0] pat, bad_a, sum_cc, tmp;
    bit          acc, saw;
    int          sent;

    initial begin
        for (int i = 0; i < 16; i++) pat[3*i +: 3] = 3'(i % 5);
        bad_a = rep16(3'b011);
        bad_a[11:9] = 3'b111;
        sum_cc = rep16(3'b001);
        sum_cc[2:0] = 3'b000;

        tbl[0] = mk("p1+p1", rep16(3'b011), rep16(3'b011), 3'b010, 1'b0,
                    rep16(3'b100), 3'b010, 1'b0);
        tbl[1] = mk("p2+p1 chain", rep16(3'b100), rep16(3'b011), 3'b010,
                    1'b0, sum_cc, 3'b011, 1'b0);
        tbl[2] = mk("a-a", pat, pat, 3'b010, 1'b1,
                    rep16(3'b010), 3'b010, 1'b0);
        tbl[3] = mk("0-p2", rep16(3'b010), rep16(3'b100), 3'b010, 1'b1,
                    rep16(3'b000), 3'b010, 1'b0);
        tbl[4] = mk("bad digit3", bad_a, rep16(3'b011), 3'b010, 1'b0,
                    rep16(3'b010), 3'b010, 1'b1);
        tbl[5] = mk("bad carry", rep16(3'b011), rep16(3'b011), 3'b100,
                    1'b0, rep16(3'b010), 3'b010, 1'b1);
        tbl[6] = mk("p2+0+cin", rep16(3'b100), rep16(3'b010), 3'b011,
                    1'b0, rep16(3'b000), 3'b011, 1'b0);
        tbl[7] = mk("m2+m2-cin", rep16(3'b000), rep16(3'b000), 3'b001,
                    1'b0, rep16(3'b010), 3'b001, 1'b0);

        rst = 1'b1;
        iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; c16 = 3'b010; sub16 = 1'b0;
        iv8 = 1'b0;  or8 = 1'b0;  a8 = '0;  b8 = '0;  c8 = 3'b010;  sub8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset out_valid", ov16, 1'b0);
        check("reset in_ready", ir16, 1'b1);
        check("reset out_sum", s16, rep16(3'b010));
        check("reset out_carry", co16, 3'b010);
        check("reset out_invalid", inv16, 1'b0);
        check("reset out_valid8", ov8, 1'b0);
        @(posedge clk); #1;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Six back-to-back operations with a three-cycle consumer stall.
        mon16 = 1'b1;
        sent = 0;
        for (int t = 0; t < 40 && got16 < 6; t++) begin
            iv16 = (sent < 6);
            tmp = rnd_op(16); a16 = tmp;
            tmp = rnd_op(16); b16 = tmp;
            c16 = 3'($urandom_range(1, 3));
            sub16 = 1'($urandom_range(0, 1));
            or16 = !(t >= 5 && t < 8);
            if (t == 6) begin
                #1;
                check("bp stall out_valid", ov16, 1'b1);
                check("bp stall in_ready", ir16, 1'b0);
            end
            @(negedge clk);
            acc = iv16 && ir16;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        iv16 = 1'b0;
        check("bp results", got16, 6);
        check("bp leftover", q16.size(), 0);

        // Reset with three operations in flight.
        or16 = 1'b1;
        for (int t = 0; t < 3; t++) begin
            iv16 = 1'b1;
            tmp = rnd_op(16); a16 = tmp;
            tmp = rnd_op(16); b16 = tmp;
            c16 = 3'b010;
            @(posedge clk); #1;
        end
        iv16 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        saw = ov16;
        repeat (10) begin
            @(posedge clk); #1;
            saw = saw | ov16;
        end
        check("no valid after reset", saw, 1'b0);
        mon16 = 1'b0;

        // Randomized traffic on the 8-digit, 2-digit-chunk instance.
        sent = 0;
        for (int cyc = 0; cyc < 20000 && (sent < 500 || got8 < 500); cyc++) begin
            iv8 = (sent < 500) && ($urandom_range(0, 3) != 0);
            tmp = rnd_op(8); a8 = tmp[23:0];
            tmp = rnd_op(8); b8 = tmp[23:0];
            c8 = 3'($urandom_range(1, 3));
            sub8 = 1'($urandom_range(0, 1));
            or8 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = iv8 && ir8;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        iv8 = 1'b0;
        check("rand8 results", got8, 500);
        check("rand8 leftover", q8.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pentary_addsub_pipe.md
Name: pentary_addsub_pipe

Overview:
- Parametrised, pipelined N-digit balanced-pentary adder/subtractor. Successor to the 16-digit combinational ripple adder.
- Splits the carry chain into registered chunks of STAGE_DIGITS digits.
- Adds a subtract mode, an invalid-code flag and a valid/ready handshake with full backpressure.
- Sits between the register-file read port and the ALU result mux; one operation accepted per cycle at full throughput.

Parameters:
DIGITS, 16, number of pentary digits per operand; must be a multiple of STAGE_DIGITS
STAGE_DIGITS, 4, digits resolved per pipeline stage; STAGES = DIGITS/STAGE_DIGITS

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operation offered
in_ready  out  1  block can accept; transfer when in_valid && in_ready
in_a  in  3*DIGITS  operand A, digit 0 in bits [2:0]
in_b  in  3*DIGITS  operand B
in_carry  in  3  carry-in digit, legal values -1/0/+1 only
in_sub  in  1  1: A - B + carry; 0: A + B + carry
out_valid  out  1  result available
out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
out_sum  out  3*DIGITS  result digits
out_carry  out  3  final carry digit (-1/0/+1)
out_invalid  out  1  an operand digit or the carry-in held an illegal code

Behaviour:
- Digit encoding:
  - 000=-2, 001=-1, 010=0, 011=+1, 100=+2.
  - 101/110/111 are illegal.
  - A carry-in of ±2 is illegal.
- Digit cell: t = a + b + c.
  - t>2: sum=t-5, carry=+1.
  - t<-2: sum=t+5, carry=-1.
  - otherwise sum=t, carry=0.
- Subtract: each digit of B is negated before the add (code' = 3'b100 - code). 010 maps to itself. in_carry is not negated.
- Pipeline structure:
  - Stage k (0..STAGES-1) resolves digits [k*STAGE_DIGITS +: STAGE_DIGITS] using the carry registered by stage k-1. Stage 0 uses in_carry.
  - Higher-chunk operands are skewed via registers.
  - Resolved lower-chunk sums are carried forward, so the result is de-skewed at the output.
- Latency: exactly STAGES cycles from input handshake to out_valid, with no stalls.
- Throughput: 1 operation per cycle.
- Flow control:
  - Single global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv, a combinational function of out_valid and out_ready only; it must not depend on in_valid.
  - When adv=0, all stage registers, valid bits, out_sum, out_carry and out_invalid hold stable.
  - Bubbles (in_valid=0 on an advance cycle) propagate as valid=0; the data registers may update.
- Invalid handling:
  - Any illegal code in in_a, in_b or in_carry sets that operation's invalid bit.
  - The invalid bit travels with the operation; out_invalid=1 is asserted alongside out_valid.
  - For an invalid operation, out_sum = all 010 and out_carry = 010.
  - Invalid operations still consume one slot and complete normally.
- Reset:
  - On a clk edge with rst=1, all stage valid bits clear.
  - Reset values: out_valid=0, out_invalid=0, out_sum = all 010, out_carry=010, internal carry registers=010.
  - in_ready=1 in the cycle after reset, since out_valid=0.
- Reset mid-operation: in-flight operations are discarded; none emerges after reset deasserts.
- Simultaneous events:
  - Input accept and output pop in the same cycle are legal, and throughput is maintained.
  - rst has priority over any handshake.
- Degenerate case STAGES=1: latency 1, behaviour otherwise identical.

Decomposition:
- Shared package pentary_pkg holds:
  - digit width constant PENT_W=3;
  - code constants PENT_M2, PENT_M1, PENT_Z, PENT_P1, PENT_P2;
  - functions pent_neg and pent_is_legal.
- Sub-module pentary_chunk_adder: combinational STAGE_DIGITS-wide ripple of digit cells with carry in/out. It is instantiated once per stage inside a generate loop.
- Pipeline registers, skew/de-skew and handshake live in the top module.

Test Plan:
- Reset, DIGITS=16, STAGE_DIGITS=4: after rst, out_valid=0, in_ready=1, out_sum=all 010. Then A=all +1, B=all +1, sub=0, cin=0 -> exactly 4 cycles later out_sum=all 100, out_carry=010, out_invalid=0.
- Carry chain across stage boundaries: A=all +2, B=all +1, cin=0 -> digit0=-2 (000), digits1..15=-1 (001), out_carry=+1 (011).
- Subtract: A=B=arbitrary legal pattern, sub=1, cin=0 -> out_sum=all 010, out_carry=010. Also A=0, B=all +2, sub=1 -> all 000, carry 010.
- Backpressure: stream 6 back-to-back operations with out_ready held low for 3 cycles mid-stream.
  - in_ready drops while out_valid=1.
  - Outputs are stable during the stall.
  - All 6 results arrive in order with no loss or duplication.
- Invalid and reset:
  - in_a digit3 = 111 -> out_invalid=1, out_sum=all 010.
  - Assert rst for 1 cycle with 3 operations in flight -> no out_valid pulse afterwards.
- Randomised, DIGITS=8, STAGE_DIGITS=2: 500 random legal operations with random in_valid/out_ready. Each result is compared against an integer model, (A ± B + cin) = sum + carry·5^8.
